uart_rx_oversampled: RTL

- Receive half of the UART. Deserialises an asynchronous 8N1 (optional parity) line driven from an `io_in` pin into parallel bytes.
- Sits beside the transmitter inside the SpinalHDL-side `uart` hierarchy, in the `clk` domain.
- Delivers each byte as a one-cycle strobe, plus framing/parity error strobes, to the command decoder.
- Counter-based bit timing only; no async logic apart from the input synchroniser.

---
 rtl/uart_rx_oversampled.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_oversampled.sv
// UART receiver: 2-flop synchroniser plus a counter-timed FSM that samples mid-bit,
// delivering 8N1 (optional parity) frames as one-cycle data/error strobes.
module uart_rx_oversampled #(
  parameter int DIVISOR    = 8,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       io_rxd,
  output logic [7:0] io_data,
  output logic       io_valid,
  output logic       io_frameError,
  output logic       io_parityError,
  output logic       io_busy
);

  localparam int TW = $clog2(DIVISOR);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TIMER_HALF = TW'(DIVISOR / 2 - 1);
  localparam logic [TW-1:0] TIMER_FULL = TW'(DIVISOR - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_e;

  state_e               state_q, state_d;
  logic [1:0]           sync_q;
  logic [TW-1:0]        timer_q, timer_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 armed_q, armed_d;
  logic [7:0]           data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 fe_q, fe_d;
  logic                 pe_q, pe_d;

  logic rxs;
  logic sample;
  logic parity_calc;

  assign rxs         = sync_q[1];
  assign sample      = (timer_q == '0);
  assign parity_calc = (^shift_q) ^ (PARITY_ODD != 0);

  // NOTE: every variable gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_d   = state_q;
    timer_d   = sample ? TIMER_FULL : timer_q - TW'(1);
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    armed_d   = armed_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    fe_d      = 1'b0;
    pe_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // A fresh reset must see the line high before the first start edge counts.
        if (!armed_q) begin
          state_d = S_WAIT_IDLE;
        end else if (!rxs) begin
          state_d   = S_START;
          timer_d   = TIMER_HALF;
          bit_cnt_d = '0;
          par_err_d = 1'b0;
        end
      end
      S_START: begin
        if (sample) state_d = rxs ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (sample) begin
          shift_d   = {rxs, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == LAST_BIT) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (sample) begin
          par_err_d = (rxs != parity_calc);
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (sample) begin
          data_d = 8'(shift_q);
          if (rxs) begin
            valid_d = !par_err_q;
            pe_d    = par_err_q;
            state_d = S_IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (rxs) begin
          state_d = S_IDLE;
          armed_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      sync_q    <= 2'b11;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_err_q <= 1'b0;
      armed_q   <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      pe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[0], io_rxd};
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_err_q <= par_err_d;
      armed_q   <= armed_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      pe_q      <= pe_d;
    end
  end

  assign io_data        = data_q;
  assign io_valid       = valid_q;
  assign io_frameError  = fe_q;
  assign io_parityError = pe_q;
  assign io_busy        = (state_q != S_IDLE);

endmodule
